aes_key_sched_ctrl: RTL

//  Sequences the 128-bit pipelined round-key expander and gates its use by the AES cipher core.
//  - Owns the expander's key input (exp_key) and holds it stable while keys settle.
//  - Asserts keys_valid only once key_s0..key_s10 all derive from the same key.
//  - Grants cipher-block issue only while keys are valid.
//  - On rekey, drains in-flight blocks before changing exp_key.

---
 rtl/aes_pkg.sv | 16 +
 rtl/aes_inflight_cnt.sv | 47 ++++
 rtl/aes_key_sched_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES key-schedule types and constants
package aes_pkg;

  // Pipeline depth of the round-key expander, from key input to key_s10.
  localparam int AES_KEY_EXPAND_LAT = 10;

  typedef enum logic [1:0] {
    KS_IDLE,
    KS_LOAD,
    KS_READY,
    KS_DRAIN
  } ks_state_t;

  typedef logic [127:0] aes_key_t;

endpackage

// File: rtl/aes_inflight_cnt.sv
// rtl/aes_inflight_cnt.sv - saturating outstanding-block counter with sticky underflow flag
module aes_inflight_cnt #(
  parameter int MAX_COUNT = 15,
  parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next,
  output logic             err_underflow
);

  logic at_zero;
  logic at_max;
  logic inc_eff;
  logic dec_eff;

  // Next count: a retire at zero is dropped, an issue at the ceiling is dropped.
  always_comb begin
    at_zero    = (count == '0);
    at_max     = (count == CNT_W'(MAX_COUNT));
    inc_eff    = inc && !at_max;
    dec_eff    = dec && !at_zero;
    count_next = count;
    if (inc_eff && !dec_eff) begin
      count_next = count + 1'b1;
    end else if (!inc_eff && dec_eff) begin
      count_next = count - 1'b1;
    end
  end

  // Count register and sticky underflow; only reset clears the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= '0;
      err_underflow <= 1'b0;
    end else begin
      count <= count_next;
      if (dec && at_zero) begin
        err_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - round-key expander sequencing and cipher issue gating
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int SETTLE_CYCLES = AES_KEY_EXPAND_LAT,
  parameter int MAX_INFLIGHT  = 15,
  parameter int EPOCH_W       = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [127:0]                      key_in,
  input  logic                              key_load_valid,
  output logic                              key_load_ready,
  output logic [127:0]                      exp_key,
  output logic                              keys_valid,
  output logic [EPOCH_W-1:0]                key_epoch,
  input  logic                              use_req,
  output logic                              use_gnt,
  input  logic                              blk_done,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              err_underflow
);

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int CNT_W    = $clog2(MAX_INFLIGHT + 1);

  ks_state_t          state;
  ks_state_t          state_next;
  aes_key_t           pend_key;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [CNT_W-1:0]   inflight_next;
  logic               accept;
  logic               settle_done;
  logic               drained;

  aes_inflight_cnt #(
    .MAX_COUNT(MAX_INFLIGHT),
    .CNT_W    (CNT_W)
  ) u_inflight (
    .clk          (clk),
    .rst          (rst),
    .inc          (use_gnt),
    .dec          (blk_done),
    .count        (inflight),
    .count_next   (inflight_next),
    .err_underflow(err_underflow)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= KS_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: a rekey in READY only reloads once the core pipeline is empty.
  always_comb begin
    accept      = key_load_valid && key_load_ready;
    settle_done = (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1));
    drained     = (inflight_next == '0);
    state_next  = state;
    case (state)
      KS_IDLE:  if (accept) state_next = KS_LOAD;
      KS_READY: if (accept) state_next = drained ? KS_LOAD : KS_DRAIN;
      KS_DRAIN: if (drained) state_next = KS_LOAD;
      KS_LOAD:  if (settle_done) state_next = KS_READY;
      default:  state_next = KS_IDLE;
    endcase
  end

  // Handshake outputs; a pending key load blocks issue so the rekey is never starved.
  always_comb begin
    key_load_ready = (state == KS_IDLE) || (state == KS_READY);
    use_gnt        = use_req && (state == KS_READY) && !key_load_valid &&
                     (inflight < CNT_W'(MAX_INFLIGHT));
  end

  // Key, settle timer and epoch registers; old keys stay on the expander while draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_key    <= '0;
      pend_key   <= '0;
      keys_valid <= 1'b0;
      key_epoch  <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        KS_IDLE: begin
          if (accept) begin
            exp_key    <= key_in;
            settle_cnt <= '0;
          end
        end
        KS_READY: begin
          if (accept) begin
            pend_key   <= key_in;
            keys_valid <= 1'b0;
            if (drained) begin
              exp_key    <= key_in;
              settle_cnt <= '0;
            end
          end
        end
        KS_DRAIN: begin
          if (drained) begin
            exp_key    <= pend_key;
            settle_cnt <= '0;
          end
        end
        KS_LOAD: begin
          if (settle_done) begin
            settle_cnt <= '0;
            keys_valid <= 1'b1;
            key_epoch  <= key_epoch + 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
